// File: rtl/frac_pkg.sv
// Shared types and constants for the fractional-search sequencer.
package frac_pkg;

   localparam int BLK_ROWS = 8;
   localparam int ROW_W    = $clog2(BLK_ROWS);
   localparam int PIX_W    = 64;
   localparam int MV_W     = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_OUT,
      ST_FIN
   } state_t;

endpackage

// File: rtl/frac_row_fetch.sv
// Row/block address generation for the two row memories, plus the
// read-strobe to engine input_ready alignment flop.
module frac_row_fetch
   import frac_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              fetch,
   input  logic              blk_next,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              eng_input_ready,
   output logic              last_row,
   output logic [CNT_W-1:0]  blk_idx
);

   logic [ADDR_W-1:0] base_q;
   logic [ROW_W-1:0]  row;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q          <= '0;
         row             <= '0;
         blk_idx         <= '0;
         eng_input_ready <= 1'b0;
      end else begin
         eng_input_ready <= fetch;
         if (load) begin
            base_q  <= base_addr;
            row     <= '0;
            blk_idx <= '0;
         end else if (blk_next) begin
            blk_idx <= blk_idx + 1'b1;
            row     <= '0;
         end else if (fetch) begin
            row <= row + 1'b1;
         end
      end
   end

   // {blk_idx, row} is 8*b + r; the cast and add wrap modulo 2^ADDR_W
   always_comb begin
      mem_rd_en   = fetch;
      mem_rd_addr = fetch ? (base_q + ADDR_W'({blk_idx, row})) : '0;
      last_row    = (row == ROW_W'(BLK_ROWS - 1));
   end

endmodule

// File: rtl/frac_search_ctrl.sv
// Sequencer for the quarter-pel fractional search engine: streams 8 row
// pairs per block, waits the engine latency, presents the mv on valid/ready.
module frac_search_ctrl
   import frac_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int CNT_W      = 6,
   parameter int RESULT_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_blks,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [PIX_W-1:0]  filter_rd_data,
   input  logic [PIX_W-1:0]  ref_rd_data,
   output logic [PIX_W-1:0]  eng_filter_pix,
   output logic [PIX_W-1:0]  eng_ref_pix,
   output logic              eng_input_ready,
   input  logic [MV_W-1:0]   eng_mvx,
   input  logic [MV_W-1:0]   eng_mvy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [MV_W-1:0]   res_mvx,
   output logic [MV_W-1:0]   res_mvy,
   output logic [CNT_W-1:0]  res_blk_idx
);

   localparam int LAT_W = (RESULT_LAT < 1) ? 1 : $clog2(RESULT_LAT + 1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  nblk_q;
   logic [CNT_W-1:0]  blk_idx;
   logic [LAT_W-1:0]  drain_cnt;
   logic              load, fetch, blk_next;
   logic              last_row, last_blk, drain_end;

   assign eng_filter_pix = filter_rd_data;
   assign eng_ref_pix    = ref_rd_data;

   frac_row_fetch #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_row_fetch (
      .clk             (clk),
      .reset           (reset),
      .load            (load),
      .base_addr       (base_addr),
      .fetch           (fetch),
      .blk_next        (blk_next),
      .mem_rd_en       (mem_rd_en),
      .mem_rd_addr     (mem_rd_addr),
      .eng_input_ready (eng_input_ready),
      .last_row        (last_row),
      .blk_idx         (blk_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // DRAIN lasts RESULT_LAT+1 cycles: the last input_ready cycle plus the latency
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nblk_q      <= '0;
         drain_cnt   <= '0;
         res_mvx     <= '0;
         res_mvy     <= '0;
         res_blk_idx <= '0;
      end else begin
         if (load) nblk_q <= num_blks;
         if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
         else                   drain_cnt <= '0;
         if (drain_end) begin
            res_mvx     <= eng_mvx;
            res_mvy     <= eng_mvy;
            res_blk_idx <= blk_idx;
         end
      end
   end

   assign drain_end = (state == ST_DRAIN) && (drain_cnt == LAT_W'(RESULT_LAT));
   assign last_blk  = (({1'b0, blk_idx} + (CNT_W + 1)'(1)) == {1'b0, nblk_q});

   always_comb begin
      state_nx  = state;
      load      = 1'b0;
      blk_next  = 1'b0;
      fetch     = (state == ST_FETCH);
      busy      = (state == ST_FETCH) || (state == ST_DRAIN) || (state == ST_OUT);
      done      = (state == ST_FIN);
      res_valid = (state == ST_OUT);
      case (state)
         ST_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = (num_blks == '0) ? ST_FIN : ST_FETCH;
            end
         end
         ST_FETCH: if (last_row) state_nx = ST_DRAIN;
         ST_DRAIN: if (drain_end) state_nx = ST_OUT;
         ST_OUT: begin
            if (res_ready) begin
               if (last_blk) begin
                  state_nx = ST_FIN;
               end else begin
                  blk_next = 1'b1;
                  state_nx = ST_FETCH;
               end
            end
         end
         ST_FIN:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_frac_search_ctrl.sv
// Self-checking bench for frac_search_ctrl: table of jobs, address/result
// scoreboards, cycle-accurate timing checks, stall and reset-abort sequences.
module tb_frac_search_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  base_addr;
   logic [5:0]  num_blks;
   logic        busy, done, mem_rd_en, eng_input_ready, res_valid, res_ready;
   logic [9:0]  mem_rd_addr;
   logic [63:0] filter_rd_data, ref_rd_data, eng_filter_pix, eng_ref_pix;
   logic [2:0]  eng_mvx, eng_mvy, res_mvx, res_mvy;
   logic [5:0]  res_blk_idx;

   frac_search_ctrl #(
      .ADDR_W     (10),
      .CNT_W      (6),
      .RESULT_LAT (1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .base_addr       (base_addr),
      .num_blks        (num_blks),
      .busy            (busy),
      .done            (done),
      .mem_rd_en       (mem_rd_en),
      .mem_rd_addr     (mem_rd_addr),
      .filter_rd_data  (filter_rd_data),
      .ref_rd_data     (ref_rd_data),
      .eng_filter_pix  (eng_filter_pix),
      .eng_ref_pix     (eng_ref_pix),
      .eng_input_ready (eng_input_ready),
      .eng_mvx         (eng_mvx),
      .eng_mvy         (eng_mvy),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_mvx         (res_mvx),
      .res_mvy         (res_mvy),
      .res_blk_idx     (res_blk_idx)
   );

   always #5 clk = ~clk;

   // row memories (1-cycle read latency) and a toy engine folding rows by XOR
   logic [63:0] fmem [1024];
   logic [63:0] rmem [1024];
   logic [63:0] eng_acc = '0;
   logic        eng_prev_ir = 1'b0;
   int          edges = 0;

   always @(posedge clk) begin
      edges <= edges + 1;
      if (mem_rd_en) begin
         filter_rd_data <= fmem[mem_rd_addr];
         ref_rd_data    <= rmem[mem_rd_addr];
      end
      if (eng_input_ready)
         eng_acc <= (eng_prev_ir ? eng_acc : 64'd0) ^ (eng_filter_pix ^ eng_ref_pix);
      eng_prev_ir <= eng_input_ready;
   end
   assign eng_mvx = eng_acc[2:0];
   assign eng_mvy = eng_acc[5:3];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   typedef struct {
      logic [9:0] base;
      logic [5:0] nblk;
      int         stall;
      bit         poke;
      int         exp_done;
      int         exp_reads;
      bit         exp_busy1;
   } vec_t;

   logic [9:0]  addr_q [$];
   logic [11:0] sb_q   [$];

   int  e0 = 0;
   bit  job_active = 0;
   int  stall_left = 0;
   int  first_rd, first_ir, first_valid, done_rel, n_rd;
   bit  busy1;
   bit  prev_rd = 0, prev_accept = 0, prev_stall = 0;
   logic [11:0] prev_res;

   // monitor: also owns res_ready so backpressure and checks see the same value
   initial begin
      forever begin
         int  rel;
         bit  accept;
         logic [11:0] exp_e;
         logic [9:0]  exp_a;
         @(negedge clk);
         rel = edges - e0 + 1;
         if (res_valid && stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
         end else begin
            res_ready = 1'b1;
         end
         accept = 0;
         if (job_active) begin
            chk("ir_delay", eng_input_ready, prev_rd);
            if (mem_rd_en) begin
               if (first_rd < 0) first_rd = rel;
               n_rd++;
               if (addr_q.size() == 0) chk("extra_read", 1, 0);
               else begin
                  exp_a = addr_q.pop_front();
                  chk("rd_addr", mem_rd_addr, exp_a);
               end
            end
            if (eng_input_ready && first_ir < 0) first_ir = rel;
            if (res_valid) begin
               if (first_valid < 0) first_valid = rel;
               chk("no_read_in_out", mem_rd_en, 0);
               if (prev_stall) chk("res_stable", {res_blk_idx, res_mvx, res_mvy}, prev_res);
            end
            if (rel == 1) busy1 = busy;
            if (prev_accept && sb_q.size() > 0) chk("resume_read", mem_rd_en, 1);
            accept = res_valid && res_ready;
            if (accept) begin
               if (sb_q.size() == 0) chk("extra_result", 1, 0);
               else begin
                  exp_e = sb_q.pop_front();
                  chk("result", {res_blk_idx, res_mvx, res_mvy}, exp_e);
               end
            end
            prev_stall = res_valid && !res_ready;
            prev_res   = {res_blk_idx, res_mvx, res_mvy};
            if (done && done_rel < 0) begin
               done_rel = rel;
               chk("busy_at_done", busy, 0);
            end
         end
         prev_rd     = mem_rd_en;
         prev_accept = accept;
      end
   end

   task automatic launch(input vec_t v);
      logic [63:0] acc;
      logic [9:0]  a;
      @(negedge clk); #1;
      addr_q.delete();
      sb_q.delete();
      for (int b = 0; b < int'(v.nblk); b++) begin
         acc = '0;
         for (int r = 0; r < 8; r++) begin
            a = 10'(int'(v.base) + 8 * b + r);
            addr_q.push_back(a);
            acc ^= fmem[a] ^ rmem[a];
         end
         sb_q.push_back({6'(b), acc[2:0], acc[5:3]});
      end
      first_rd = -1; first_ir = -1; first_valid = -1; done_rel = -1; n_rd = 0;
      busy1 = 0; prev_stall = 0;
      stall_left = v.stall;
      start = 1'b1; base_addr = v.base; num_blks = v.nblk;
      e0 = edges + 1;
      job_active = 1;
      @(negedge clk); #1;
      start = 1'b0;
      if (v.poke) begin
         @(negedge clk); #1;
         @(negedge clk); #1;
         start = 1'b1; base_addr = 10'h2AA; num_blks = 6'd7;
         @(negedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic finish_job(input vec_t v);
      int guard = 0;
      while (done_rel < 0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      #1;
      chk("done_timeout", guard >= 3000, 0);
      chk("done_cycle", done_rel, v.exp_done);
      chk("read_count", n_rd, v.exp_reads);
      chk("busy_cycle1", busy1, v.exp_busy1);
      chk("first_read", first_rd, (v.nblk != 0) ? 1 : -1);
      chk("first_ir", first_ir, (v.nblk != 0) ? 2 : -1);
      chk("first_valid", first_valid, (v.nblk != 0) ? 11 : -1);
      chk("addr_q_empty", addr_q.size(), 0);
      chk("sb_empty", sb_q.size(), 0);
      job_active = 0;
   endtask

   vec_t vecs [7];

   initial begin
      vec_t abort_v;
      int   guard;
      vecs[0] = '{10'h010, 6'd1, 0, 1'b0, 12, 8,  1'b1};
      vecs[1] = '{10'h020, 6'd3, 0, 1'b0, 34, 24, 1'b1};
      vecs[2] = '{10'h100, 6'd2, 5, 1'b0, 28, 16, 1'b1};
      vecs[3] = '{10'h3FC, 6'd1, 0, 1'b0, 12, 8,  1'b1};
      vecs[4] = '{10'h000, 6'd0, 0, 1'b0, 1,  0,  1'b0};
      vecs[5] = '{10'h040, 6'd2, 0, 1'b1, 23, 16, 1'b1};
      vecs[6] = '{10'h3F8, 6'd3, 2, 1'b0, 36, 24, 1'b1};
      abort_v = '{10'h080, 6'd2, 0, 1'b0, 23, 16, 1'b1};

      for (int i = 0; i < 1024; i++) begin
         fmem[i] = {$urandom(), $urandom()};
         rmem[i] = {$urandom(), $urandom()};
      end

      reset = 1'b0; start = 1'b0; base_addr = '0; num_blks = '0; res_ready = 1'b1;
      #1;
      chk("reset_outputs", {busy, done, mem_rd_en, mem_rd_addr, eng_input_ready,
                            res_valid, res_mvx, res_mvy, res_blk_idx}, 0);
      #21 reset = 1'b1;
      @(negedge clk);
      chk("idle_outputs", {busy, done, mem_rd_en, res_valid}, 0);

      for (int i = 0; i < 7; i++) begin
         launch(vecs[i]);
         finish_job(vecs[i]);
      end

      // abort in cycle 5 of FETCH, then a clean job after release
      launch(abort_v);
      guard = 0;
      while ((edges - e0 + 1) < 5 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      #2;
      job_active = 0;
      reset = 1'b0;
      #1;
      chk("abort_outputs", {busy, done, mem_rd_en, mem_rd_addr, eng_input_ready,
                            res_valid, res_mvx, res_mvy, res_blk_idx}, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("abort_hold", {busy, done, mem_rd_en, eng_input_ready, res_valid}, 0);
      end
      #1 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_abort_idle", {busy, done, mem_rd_en, res_valid}, 0);
      end
      launch(abort_v);
      finish_job(abort_v);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
